// File: rtl/agc_sim_pkg.sv
// Shared definitions for the AGC simulation blocks: uplink FSM states,
// frame length and default uplink timing.
package agc_sim_pkg;

    typedef enum logic [2:0] {
        UPL_IDLE  = 3'd0,
        UPL_ARM   = 3'd1,
        UPL_PULSE = 3'd2,
        UPL_GAP   = 3'd3,
        UPL_WGAP  = 3'd4
    } upl_state_e;

    localparam int UPLINK_FRAME_LEN     = 16;
    localparam int UPL_PULSE_CYC_DEF    = 10;
    localparam int UPL_GAP_CYC_DEF      = 30;
    localparam int UPL_WORD_GAP_CYC_DEF = 200;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/uplink_interval_timer.sv
// Loadable down-counter; zero is high once the loaded interval has elapsed.
// Loading N-1 keeps the caller's state alive for exactly N cycles.
module uplink_interval_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/uplink_tx.sv
// Serialises a 15-bit uplink word into 16 UPL0/UPL1 pulses (start pulse + MSB-first data)
// toward the AGC, honouring the BLKUPL_n inhibit between pulses.
//
// state | meaning
// IDLE  | word_ready high, waiting for a word
// ARM   | waiting for BLKUPL_n=1 before starting the next pulse
// PULSE | UPL0 or UPL1 high for PULSE_CYC cycles
// GAP   | both low for GAP_CYC cycles; exits straight to PULSE when unblocked
// WGAP  | inter-word idle for WORD_GAP_CYC cycles
module uplink_tx
    import agc_sim_pkg::*;
#(
    parameter int PULSE_CYC    = UPL_PULSE_CYC_DEF,
    parameter int GAP_CYC      = UPL_GAP_CYC_DEF,
    parameter int WORD_GAP_CYC = UPL_WORD_GAP_CYC_DEF
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST_n,
    input  logic        word_valid,
    input  logic [14:0] word_data,
    output logic        word_ready,
    input  logic        BLKUPL_n,
    output logic        UPL0,
    output logic        UPL1,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] IDLE  = UPL_IDLE;
    localparam logic [2:0] ARM   = UPL_ARM;
    localparam logic [2:0] PULSE = UPL_PULSE;
    localparam logic [2:0] GAP   = UPL_GAP;
    localparam logic [2:0] WGAP  = UPL_WGAP;

    localparam int MAXC = max3(PULSE_CYC, GAP_CYC, WORD_GAP_CYC);
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    if (PULSE_CYC < 1 || GAP_CYC < 1 || WORD_GAP_CYC < 1) begin : g_bad_timing
        $error("uplink_tx: PULSE_CYC, GAP_CYC and WORD_GAP_CYC must all be >= 1");
    end

    logic [2:0]    state, state_nxt;
    logic [15:0]   shreg;
    logic [4:0]    bit_cnt;
    logic          rdy_en;
    logic          upl0_q, upl1_q, done_q;
    logic          tmr_load, tmr_zero;
    logic [TW-1:0] tmr_val;
    logic          accept, last_bit;

    assign word_ready = (state == IDLE) && rdy_en;
    assign accept     = word_valid && word_ready;
    assign last_bit   = (bit_cnt == 5'(UPLINK_FRAME_LEN - 1));

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            IDLE: if (accept) state_nxt = ARM;
            ARM: if (BLKUPL_n) begin
                state_nxt = PULSE;
                tmr_load  = 1'b1;
                tmr_val   = TW'(PULSE_CYC - 1);
            end
            PULSE: if (tmr_zero) begin
                state_nxt = GAP;
                tmr_load  = 1'b1;
                tmr_val   = TW'(GAP_CYC - 1);
            end
            GAP: if (tmr_zero) begin
                if (last_bit) begin
                    state_nxt = WGAP;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(WORD_GAP_CYC - 1);
                end else if (BLKUPL_n) begin
                    // gap already provided the arming cycle; no extra ARM cycle between pulses
                    state_nxt = PULSE;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(PULSE_CYC - 1);
                end else begin
                    state_nxt = ARM;
                end
            end
            WGAP: if (tmr_zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            rdy_en  <= 1'b0;
            upl0_q  <= 1'b0;
            upl1_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            upl1_q <= (state_nxt == PULSE) && shreg[15];
            upl0_q <= (state_nxt == PULSE) && !shreg[15];
            done_q <= (state == PULSE) && tmr_zero && last_bit;
            if (accept) begin
                shreg   <= {1'b1, word_data};
                bit_cnt <= '0;
            end else if (state == PULSE && tmr_zero) begin
                shreg <= {shreg[14:0], 1'b0};
            end
            if (state == GAP && tmr_zero && !last_bit) bit_cnt <= bit_cnt + 5'd1;
        end
    end

    uplink_interval_timer #(.W(TW)) u_timer (
        .clk      (SIM_CLK),
        .rst_n    (SIM_RST_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign UPL0 = upl0_q;
    assign UPL1 = upl1_q;
    assign done = done_q;
    assign busy = (state != IDLE);

endmodule
